// File: rtl/hier_path_walker_if.sv
// Leaf-path stream between the walker and its consumer.
interface hier_path_walker_if #(
  parameter int DEPTH   = 10,
  parameter int DIGIT_W = 3
);
  logic                     path_valid;
  logic                     path_ready;
  logic [DEPTH*DIGIT_W-1:0] path;
  logic                     path_last;

  modport master (output path_valid, output path, output path_last, input path_ready);
  modport slave  (input path_valid, input path, input path_last, output path_ready);
endinterface

// File: rtl/hier_path_walker.sv
// Walks every leaf path of a uniform tree (fixed fanout, programmable depth)
// in lexicographic order and streams one path per valid/ready transfer.

// One digit of the mixed-radix path counter; wraps FANOUT-1 -> 0.
module hier_path_walker_digit #(
  parameter int FANOUT  = 5,
  parameter int DIGIT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] digit,
  output logic               at_max
);
  localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(FANOUT - 1);

  logic [DIGIT_W-1:0] digit_q, digit_d;

  // Next digit: clear wins, otherwise increment with wrap at FANOUT-1.
  always_comb begin
    digit_d = digit_q;
    if (clr)      digit_d = '0;
    else if (inc) digit_d = (digit_q == MAX_D) ? '0 : digit_q + 1'b1;
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) digit_q <= '0;
    else        digit_q <= digit_d;
  end

  assign digit  = digit_q;
  assign at_max = (digit_q == MAX_D);
endmodule

module hier_path_walker #(
  parameter int DEPTH   = 10,
  parameter int FANOUT  = 5,
  parameter int DIGIT_W = 3,
  parameter int CNT_W   = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [$clog2(DEPTH+1)-1:0] cfg_depth,
  hier_path_walker_if.master         pif,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           count
);
  localparam int DW = $clog2(DEPTH + 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                         state_q, state_d;
  logic [DW-1:0]                  depth_q, depth_d, depth_clamp;
  logic [CNT_W-1:0]               count_q, count_d;
  logic                           done_q, done_d;
  logic                           running, xfer, last, clr;
  logic [DEPTH-1:0]               active, lsd, at_max, inc;
  logic [DEPTH:0]                 carry;
  logic [DEPTH-1:0][DIGIT_W-1:0]  digits;

  assign running = (state_q == S_RUN);
  assign xfer    = running & pif.path_ready;
  // Digits are zeroed at the start of a walk and when a walk is cut short,
  // so path reads 0 whenever the walker is idle. A completed walk wraps to 0
  // on its own through the carry chain.
  assign clr     = ((state_q == S_IDLE) & start) | (running & abort);

  // Carry chain: the deepest active level is least significant; a carry
  // out of level i+1 increments level i. Inactive levels never move.
  assign carry[DEPTH] = 1'b0;
  for (genvar i = 0; i < DEPTH; i++) begin : g_lvl
    assign active[i] = (DW'(i) < depth_q);
    assign lsd[i]    = (DW'(i + 1) == depth_q);
    assign inc[i]    = xfer & active[i] & (lsd[i] | carry[i+1]);
    assign carry[i]  = inc[i] & at_max[i];

    hier_path_walker_digit #(.FANOUT(FANOUT), .DIGIT_W(DIGIT_W)) u_dig (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (inc[i]),
      .digit (digits[i]),
      .at_max(at_max[i])
    );
  end

  assign last = running & (&(at_max | ~active));

  // Clamp requested depth into 1..DEPTH.
  always_comb begin
    depth_clamp = cfg_depth;
    if (cfg_depth == '0)             depth_clamp = DW'(1);
    else if (cfg_depth > DW'(DEPTH)) depth_clamp = DW'(DEPTH);
  end

  // Walk control: start/abort/final-transfer sequencing and transfer count.
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          depth_d = depth_clamp;
          count_d = '0;
        end
      end
      S_RUN: begin
        if (xfer) count_d = count_q + 1'b1;
        // Abort outranks a coincident final transfer: walk ends, no done.
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer && last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      depth_q <= DW'(1);
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign pif.path_valid = running;
  assign pif.path       = digits;
  assign pif.path_last  = last;
  assign busy           = running;
  assign done           = done_q;
  assign count          = count_q;
endmodule

// File: tb/tb_hier_path_walker.sv
// Randomized directed bench for hier_path_walker against an index-based model:
// the k-th path of a walk is k written in base FANOUT, most significant digit
// at level 0.
module tb_hier_path_walker;
  localparam int DEPTH   = 10;
  localparam int FANOUT  = 5;
  localparam int DIGIT_W = 3;
  localparam int CNT_W   = 24;
  localparam int DW      = $clog2(DEPTH + 1);
  localparam int BUDGET  = 5000;

  logic          clk = 1'b0;
  logic          rst_n, start, abort;
  logic [DW-1:0] cfg_depth;
  logic          busy, done;
  logic [CNT_W-1:0] count;

  int ntot = 0, npass = 0, nfail = 0;

  hier_path_walker_if #(.DEPTH(DEPTH), .DIGIT_W(DIGIT_W)) pif ();

  hier_path_walker #(.DEPTH(DEPTH), .FANOUT(FANOUT), .DIGIT_W(DIGIT_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .cfg_depth(cfg_depth),
    .pif      (pif),
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DEPTH*DIGIT_W-1:0] exp_path(input int k, input int dep);
    logic [DEPTH*DIGIT_W-1:0] p;
    int rem;
    p = '0;
    rem = k;
    for (int i = dep - 1; i >= 0; i--) begin
      p[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(rem % FANOUT);
      rem = rem / FANOUT;
    end
    return p;
  endfunction

  // Start a walk at the current negedge and follow it to its end.
  // abort_at: model index at which abort is raised (-1 = never); abort_xfer
  // says whether path_ready is high in that same cycle. chain returns at the
  // done cycle so the caller can start again in it.
  task automatic run_walk(input int cfg, input int dep, input int rdy_pct,
                          input int abort_at, input bit abort_xfer, input bit chain);
    int tot, k, cyc;
    bit rdy, ab;
    tot = 1;
    repeat (dep) tot *= FANOUT;
    k = 0; cyc = 0; ab = 1'b0;
    start = 1'b1; cfg_depth = DW'(cfg);
    @(negedge clk);
    forever begin
      cfg_depth = DW'($urandom_range(15));
      chk("valid", 64'(pif.path_valid), 64'd1);
      chk("busy",  64'(busy), 64'd1);
      chk("path",  64'(pif.path), 64'(exp_path(k, dep)));
      chk("last",  64'(pif.path_last), 64'(k == tot - 1));
      chk("count", 64'(count), 64'(k));
      chk("done_run", 64'(done), 64'd0);
      rdy = ($urandom_range(99) < rdy_pct);
      ab  = (k == abort_at);
      if (ab) rdy = abort_xfer;
      pif.path_ready = rdy;
      abort = ab;
      start = 1'($urandom_range(1));
      @(negedge clk);
      cyc++;
      start = 1'b0; abort = 1'b0; pif.path_ready = 1'b0;
      if (rdy) k++;
      if (ab || k == tot) break;
      if (cyc >= BUDGET) begin
        chk("budget", 64'(cyc), 64'(BUDGET - 1));
        break;
      end
    end
    chk("end_valid", 64'(pif.path_valid), 64'd0);
    chk("end_busy",  64'(busy), 64'd0);
    chk("end_path",  64'(pif.path), 64'd0);
    chk("end_last",  64'(pif.path_last), 64'd0);
    chk("end_count", 64'(count), 64'(k));
    chk("end_done",  64'(done), 64'(!ab));
    if (!ab && rdy_pct >= 100) chk("cycles", 64'(cyc), 64'(tot));
    if (!chain) begin
      @(negedge clk);
      chk("done_drop", 64'(done), 64'd0);
      chk("idle_count", 64'(count), 64'(k));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_depth = '0;
    pif.path_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", 64'(pif.path_valid), 64'd0);
    chk("rst_path",  64'(pif.path), 64'd0);
    chk("rst_last",  64'(pif.path_last), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_walk(1, 1, 100, -1, 1'b0, 1'b0);   // depth 1, 5 paths
    run_walk(2, 2, 60, -1, 1'b0, 1'b0);    // depth 2 with stalls
    run_walk(3, 3, 100, -1, 1'b0, 1'b1);   // no bubbles, chained restart
    run_walk(0, 1, 100, -1, 1'b0, 1'b0);   // start in done cycle; depth 0 -> 1
    run_walk(15, 10, 70, 300, 1'b0, 1'b0); // clamp to 10, partial walk
    run_walk(2, 2, 100, 7, 1'b0, 1'b0);    // abort after 7 transfers
    run_walk(2, 2, 100, -1, 1'b0, 1'b0);   // restarts from path 0
    run_walk(2, 2, 50, 24, 1'b1, 1'b0);    // abort with final transfer

    // abort while idle has no effect
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy",  64'(busy), 64'd0);
    chk("idle_abort_valid", 64'(pif.path_valid), 64'd0);
    chk("idle_abort_count", 64'(count), 64'd25);

    // asynchronous reset in the middle of a depth-3 walk
    start = 1'b1; cfg_depth = DW'(3);
    @(negedge clk);
    start = 1'b0; pif.path_ready = 1'b1;
    repeat (9) @(negedge clk);
    chk("mid_count", 64'(count), 64'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(pif.path_valid), 64'd0);
    chk("ar_path",  64'(pif.path), 64'd0);
    chk("ar_last",  64'(pif.path_last), 64'd0);
    chk("ar_busy",  64'(busy), 64'd0);
    chk("ar_done",  64'(done), 64'd0);
    chk("ar_count", 64'(count), 64'd0);
    @(negedge clk);
    pif.path_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 64'(done), 64'd0);
    run_walk(3, 3, 80, -1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
